// File: rtl/ps2_key_decoder_if.sv
// PS/2 keyboard decoder bus: raw pins in, key events out.
// master = decoder side, slave = pin driver / event consumer.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_valid;
  logic       key_release;
  logic [7:0] key_code;
  logic       key_ext;
  logic       enter;
  logic       frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output key_valid,
    output key_release,
    output key_code,
    output key_ext,
    output enter,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  key_valid,
    input  key_release,
    input  key_code,
    input  key_ext,
    input  enter,
    input  frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 frame receiver with E0/F0 prefix resolution into key events.
// Optional odd-parity check enabled by PS2_PARITY_CHECK_EN.
module ps2_key_decoder #(
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] ENTER_CODE     = 8'h5A
) (
  input logic               clk,
  input logic               reset,
  ps2_key_decoder_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_t;

  logic          clk_s1;
  logic          clk_s2;
  logic          clk_d;
  logic          dat_s1;
  logic          dat_s2;
  logic          fall;

  state_t        state_q;
  state_t        state_d;
  logic [3:0]    bit_q;
  logic [3:0]    bit_d;
  logic [8:0]    sh_q;
  logic [8:0]    sh_d;
  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;
  logic          ext_q;
  logic          ext_d;
  logic          brk_q;
  logic          brk_d;
  logic [7:0]    code_q;
  logic [7:0]    code_d;
  logic          kext_q;
  logic          kext_d;
  logic          valid_q;
  logic          valid_d;
  logic          rel_q;
  logic          rel_d;
  logic          err_q;
  logic          err_d;
  logic          enter_q;
  logic          enter_d;
  logic          tmo;
  logic          par_ok;
  logic [7:0]    byte_v;

  // Two-flop synchronisers plus a delay flop for edge detect; idle high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= bus.ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall   = clk_d & ~clk_s2;
  assign tmo    = (tcnt_q == TW'(TIMEOUT_CYCLES));
  assign byte_v = sh_q[7:0];

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^sh_q;
`else
  logic unused_par;
  assign unused_par = sh_q[8];
  assign par_ok     = 1'b1;
`endif

  // Frame FSM, timeout and prefix decode: next state and next outputs.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tcnt_d  = tcnt_q + TW'(1);
    ext_d   = ext_q;
    brk_d   = brk_q;
    code_d  = code_q;
    kext_d  = kext_q;
    valid_d = 1'b0;
    rel_d   = 1'b0;
    err_d   = 1'b0;
    if (state_q == IDLE || fall) begin
      tcnt_d = '0;
    end
    if (state_q != IDLE && !fall && tmo) begin
      state_d = IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
      tcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fall && !dat_s2) begin
            bit_d   = 4'd0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            sh_d  = {dat_s2, sh_q[8:1]};
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd8) begin
              state_d = STOP;
            end
          end
        end
        STOP: begin
          if (fall) begin
            state_d = IDLE;
            if (dat_s2 && par_ok) begin
              unique case (1'b1)
                (byte_v == 8'hE0): ext_d = 1'b1;
                (byte_v == 8'hF0): brk_d = 1'b1;
                default: begin
                  code_d  = byte_v;
                  kext_d  = ext_q;
                  rel_d   = brk_q;
                  valid_d = ~brk_q;
                  ext_d   = 1'b0;
                  brk_d   = 1'b0;
                end
              endcase
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    enter_d = valid_d & (code_d == ENTER_CODE);
  end

  // State, datapath and registered output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      tcnt_q  <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      code_q  <= 8'h00;
      kext_q  <= 1'b0;
      valid_q <= 1'b0;
      rel_q   <= 1'b0;
      err_q   <= 1'b0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tcnt_q  <= tcnt_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      code_q  <= code_d;
      kext_q  <= kext_d;
      valid_q <= valid_d;
      rel_q   <= rel_d;
      err_q   <= err_d;
      enter_q <= enter_d;
    end
  end

  assign bus.key_valid   = valid_q;
  assign bus.key_release = rel_q;
  assign bus.key_code    = code_q;
  assign bus.key_ext     = kext_q;
  assign bus.enter       = enter_q;
  assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder.
// Directed PS/2 frames in; monitor pops expected events on each pulse.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int H   = 10;
  localparam int TMO = 300;

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       ext;
    logic       ent;
  } ev_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  ev_t  q[$];

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(TMO),
    .ENTER_CODE    (8'h5A)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] code,
                           input logic ext, input logic ent);
    ev_t e;
    e.kind = kind;
    e.code = code;
    e.ext  = ext;
    e.ent  = ent;
    q.push_back(e);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    bus.ps2_data = b;
    repeat (H) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ par_flip);
    ps2_bit(stop);
    bus.ps2_data = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(b[i]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " key_valid"},   32'(bus.key_valid),   0);
    chk({tag, " key_release"}, 32'(bus.key_release), 0);
    chk({tag, " key_code"},    32'(bus.key_code),    0);
    chk({tag, " key_ext"},     32'(bus.key_ext),     0);
    chk({tag, " enter"},       32'(bus.enter),       0);
    chk({tag, " frame_err"},   32'(bus.frame_err),   0);
  endtask

  // Monitor: every output pulse must match the next expected event.
  always @(negedge clk) begin
    if (!reset && (bus.key_valid | bus.key_release | bus.frame_err)) begin
      int  act_kind;
      ev_t e;
      chk("pulse_exclusive",
          32'(bus.key_valid) + 32'(bus.key_release) + 32'(bus.frame_err), 1);
      act_kind = bus.key_valid ? 0 : (bus.key_release ? 1 : 2);
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got kind %0d code %0h expected none",
                 act_kind, bus.key_code);
      end else begin
        e = q.pop_front();
        chk("event_kind", 32'(act_kind), 32'(e.kind));
        chk("enter", 32'(bus.enter), 32'(e.ent));
        if (e.kind != 2) begin
          chk("key_code", 32'(bus.key_code), 32'(e.code));
          chk("key_ext", 32'(bus.key_ext), 32'(e.ext));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    tests        = 0;
    fails        = 0;
    reset        = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    expect_ev(0, 8'h5A, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);

    expect_ev(1, 8'h5A, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);

    expect_ev(0, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);

    expect_ev(0, 8'h5A, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);

    expect_ev(0, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);

    expect_ev(1, 8'h75, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);

    expect_ev(0, 8'h1C, 1'b0, 1'b0);
    expect_ev(0, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);

`ifdef PS2_PARITY_CHECK_EN
    expect_ev(2, 8'h00, 1'b0, 1'b0);
`else
    expect_ev(0, 8'h5A, 1'b0, 1'b1);
`endif
    send_frame(8'h5A, 1'b1, 1'b1);

    expect_ev(2, 8'h00, 1'b0, 1'b0);
    send_partial(8'h1D, 4);
    bus.ps2_data = 1'b1;
    repeat (TMO + 100) @(negedge clk);
    expect_ev(0, 8'h1D, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b1);

    expect_ev(2, 8'h00, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_partial(8'h5A, 3);
    bus.ps2_data = 1'b1;
    repeat (TMO + 100) @(negedge clk);
    expect_ev(0, 8'h5A, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);

    expect_ev(2, 8'h00, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0);
    expect_ev(0, 8'h5A, 1'b1, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);

    send_partial(8'h6B, 5);
    bus.ps2_data = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_zero("midreset");
    repeat (TMO + 100) @(negedge clk);
    chk_zero("post_reset_idle");
    expect_ev(0, 8'h5A, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);

    repeat (50) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
